playout_stats_ctrl: RTL
=======================

# playout_stats_ctrl

Batch controller that sits directly downstream of the 2048 game core. It repeatedly resets the core, counts completed moves from the core's per-move completion pulse, and detects the stuck (game-over) condition. At game end it scans the final 80-bit board for the largest tile exponent, then accumulates per-batch statistics for the host or display logic. It also owns the core's reset line, so one `start` pulse runs `num_games` complete playouts without host involvement.

## Interface
- `MAX_MOVES`, default 65535: per-game move cap; reaching it ends the game as a timeout.
- `RST_CYCLES`, default 2: number of cycles `core_rst` is held high before each game.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: pulse that begins a batch; accepted only when `busy`=0.
- `num_games` in 16: games per batch, sampled when `start` is accepted.
- `core_calc_done` in 1: core per-move completion; stays high once the core is stuck.
- `core_stuck` in 1: core game-over flag.
- `core_board` in 80: core stored board; cell i = bits [5i+4:5i], value = tile exponent, 0 = empty.
- `core_rst` out 1: reset to the core.
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle pulse when the batch completes.
- `games_run` out 16: games completed in this batch.
- `total_moves` out 32: sum of moves over all games; saturates at 2^32-1.
- `best_moves` out 16: largest per-game move count.
- `best_tile` out 5: largest tile exponent seen in any final board.
- `timeouts` out 8: games ended by `MAX_MOVES`; saturates at 255.

## Operation
- States: IDLE, CRST, PLAY, SCAN, NEXT.
- IDLE
  - `core_rst`=1 (core held in reset).
  - On `start`: latch `num_games`, clear all statistics.
    - If `num_games`==0: pulse `done`, stay in IDLE.
    - Otherwise: go to CRST.
- CRST
  - `core_rst`=1 for `RST_CYCLES` cycles.
  - Clear the game move counter `mc`, then go to PLAY.
- PLAY
  - `core_rst`=0.
  - Register `core_calc_done` as `cd_q`.
  - A move is counted when `core_calc_done & ~cd_q & ~core_stuck`. A level held high for several cycles counts once.
  - `core_stuck`=1: go to SCAN. A `calc_done` edge in the same cycle is not counted.
  - Else if `mc`==`MAX_MOVES`: set the timeout flag and go to SCAN. `mc` never exceeds `MAX_MOVES`.
- SCAN
  - `core_rst`=1, which freezes the core board (no RAM writes while in reset).
  - 16 cycles; cell index k runs 0..15, one cell per cycle.
  - Running max: `gmax = max(gmax, cell k)`.
- NEXT (1 cycle)
  - `total_moves += mc`, saturating.
  - `best_moves = max(best_moves, mc)`.
  - `best_tile = max(best_tile, gmax)`.
  - If the timeout flag is set, `timeouts` += 1, saturating.
  - `games_run += 1`.
  - If the new `games_run` equals `num_games`: pulse `done`, go to IDLE. Otherwise go to CRST.
- `start` while `busy`=1 is ignored.
- Statistics hold after `done` until the next accepted `start`.
- `rst` at any point, including mid-PLAY or mid-SCAN, returns to IDLE on the next edge.

## Timing
- Reset values:
  - `core_rst`=1, `busy`=0, `done`=0.
  - All statistics 0.
  - `mc`=0, `cd_q`=0, state IDLE.
- `start` sampled at edge T:
  - `busy`=1 from T+1.
  - `core_rst` high T+1..T+`RST_CYCLES`.
  - PLAY from T+`RST_CYCLES`+1.
- Game end: stuck or cap detected at edge S; SCAN occupies S+1..S+16; NEXT at S+17.
- NEXT updates take effect at S+18, the same edge at which `done` (last game) or CRST (next game) begins.
- `done` and `busy` fall together: `done`=1, `busy`=0 in the cycle after NEXT.
- Per-game overhead excluding play: `RST_CYCLES` + 17 cycles.
- Statistics outputs are registered and change only at the NEXT edge or on `start`/`rst`.

## Structure
- Shared package holds:
  - Board constants: `CELLS`=16, `CELL_W`=5, `BOARD_W`=80.
  - State enum constants.
  - Saturating-add helper.
  - The same board constants are reused by the core's fill and merge stages.
- One sub-module, `board_cell_mux`: combinational 16:1 select of the 5-bit cell at index k from the 80-bit board. It is also reusable by the display path.

## Test plan
- Zero-game batch: `num_games`=0, `start` -> `done` pulse at T+1, `busy` stays 0, all statistics 0, `core_rst` stays 1.
- Single game: model core gives 3 `calc_done` pulses then `stuck`, board with exponent 7 in cell 15 -> `games_run`=1, `total_moves`=3, `best_moves`=3, `best_tile`=7, `timeouts`=0.
- Two games: 5 moves with max tile 4, then 2 moves with max tile 9 -> `total_moves`=7, `best_moves`=5, `best_tile`=9, `core_rst` pulsed `RST_CYCLES` cycles before each game.
- Timeout: `MAX_MOVES`=8, core never stuck -> game ends after the 8th move, `timeouts`=1, `core_rst`=1 throughout SCAN, board sampled unchanged across all 16 scan cycles.
- Edge detection: `calc_done` held high for 4 cycles -> counts as 1 move. `calc_done` and `stuck` rising together -> no move counted, SCAN entered.
- Robustness:
  - `start` during PLAY -> ignored, batch continues.
  - `rst` mid-PLAY -> IDLE next cycle, `busy`=0, `core_rst`=1, statistics 0.

Source files
------------

// File: rtl/playout_stats_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// playout_stats_ctrl_pkg : board geometry, controller states, saturating math
// Rev 1.0
// ---------------------------------------------------------------------------
package playout_stats_ctrl_pkg;

  localparam int CELLS   = 16;
  localparam int CELL_W  = 5;
  localparam int BOARD_W = CELLS * CELL_W;
  localparam int IDX_W   = $clog2(CELLS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CRST = 3'd1,
    ST_PLAY = 3'd2,
    ST_SCAN = 3'd3,
    ST_NEXT = 3'd4
  } state_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/playout_stats_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// playout_stats_ctrl_if : host command, core handshake and batch statistics
// Rev 1.0
// ---------------------------------------------------------------------------
interface playout_stats_ctrl_if;
  import playout_stats_ctrl_pkg::*;

  logic               start;
  logic [15:0]        num_games;
  logic               core_calc_done;
  logic               core_stuck;
  logic [BOARD_W-1:0] core_board;
  logic               core_rst;
  logic               busy;
  logic               done;
  logic [15:0]        games_run;
  logic [31:0]        total_moves;
  logic [15:0]        best_moves;
  logic [CELL_W-1:0]  best_tile;
  logic [7:0]         timeouts;

  // master: host plus game core; slave: the controller
  modport master (
    output start, num_games, core_calc_done, core_stuck, core_board,
    input  core_rst, busy, done, games_run, total_moves, best_moves,
           best_tile, timeouts
  );

  modport slave (
    input  start, num_games, core_calc_done, core_stuck, core_board,
    output core_rst, busy, done, games_run, total_moves, best_moves,
           best_tile, timeouts
  );

endinterface
`default_nettype wire

// File: rtl/playout_stats_ctrl_board_cell_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_cell_mux : combinational select of one 5-bit cell from the 80-bit board
// Rev 1.0
// ---------------------------------------------------------------------------
module board_cell_mux
  import playout_stats_ctrl_pkg::*;
(
  input  logic [BOARD_W-1:0] i_board,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [CELL_W-1:0]  o_cell
);

  logic [CELL_W-1:0] w_cells [CELLS];

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cells
    assign w_cells[gi] = i_board[gi*CELL_W +: CELL_W];
  end

  assign o_cell = w_cells[i_idx];

endmodule
`default_nettype wire

// File: rtl/playout_stats_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// playout_stats_ctrl : runs num_games 2048 playouts back to back, collects stats
// Rev 1.0
// ---------------------------------------------------------------------------
module playout_stats_ctrl
  import playout_stats_ctrl_pkg::*;
#(
  parameter int MAX_MOVES  = 65535,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  playout_stats_ctrl_if.slave  bus
);

  localparam int          RCW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [15:0] C_MAX_MOVES = 16'(MAX_MOVES);
  localparam logic [RCW-1:0] C_RST_LAST = RCW'(RST_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_num_games;
  logic [RCW-1:0]    r_rst_cnt;
  logic [15:0]       r_mc;
  logic              r_cd_q;
  logic              r_timeout;
  logic [IDX_W-1:0]  r_k;
  logic [CELL_W-1:0] r_gmax;
  logic              r_done;

  logic [15:0]       r_games_run;
  logic [31:0]       r_total_moves;
  logic [15:0]       r_best_moves;
  logic [CELL_W-1:0] r_best_tile;
  logic [7:0]        r_timeouts;

  logic              w_start_acc;
  logic              w_done_set;
  logic              w_move;
  logic              w_cap;
  logic [15:0]       w_games_inc;
  logic [CELL_W-1:0] w_cell;

  board_cell_mux u_cell_mux (
    .i_board (bus.core_board),
    .i_idx   (r_k),
    .o_cell  (w_cell)
  );

  assign w_games_inc = r_games_run + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_done_set  = 1'b0;
    w_move      = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          if (bus.num_games == 16'd0) w_done_set  = 1'b1;
          else                        w_state_nxt = ST_CRST;
        end
      end
      ST_CRST: begin
        if (r_rst_cnt == C_RST_LAST) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // stuck wins over a coincident calc_done edge and over the cap
        if (bus.core_stuck) begin
          w_state_nxt = ST_SCAN;
        end else if (r_mc == C_MAX_MOVES) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_SCAN;
        end else if (bus.core_calc_done && !r_cd_q) begin
          w_move = 1'b1;
        end
      end
      ST_SCAN: begin
        if (r_k == IDX_W'(CELLS - 1)) w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (w_games_inc == r_num_games) begin
          w_done_set  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CRST;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_rst_cnt <= '0;
      r_cd_q    <= 1'b0;
      r_mc      <= '0;
      r_timeout <= 1'b0;
      r_k       <= '0;
      r_gmax    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_set;
      r_rst_cnt <= (r_state == ST_CRST) ? r_rst_cnt + RCW'(1) : '0;
      r_cd_q    <= (r_state == ST_PLAY) ? bus.core_calc_done : 1'b0;
      r_k       <= (r_state == ST_SCAN) ? r_k + IDX_W'(1) : '0;
      if (r_state == ST_CRST) begin
        r_mc      <= '0;
        r_timeout <= 1'b0;
        r_gmax    <= '0;
      end else begin
        if (w_move) r_mc <= r_mc + 16'd1;
        if (w_cap)  r_timeout <= 1'b1;
        if (r_state == ST_SCAN && w_cell > r_gmax) r_gmax <= w_cell;
      end
    end
  end

  // batch statistics: cleared by rst or an accepted start, updated only in NEXT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_games   <= '0;
      r_games_run   <= '0;
      r_total_moves <= '0;
      r_best_moves  <= '0;
      r_best_tile   <= '0;
      r_timeouts    <= '0;
    end else if (w_start_acc) begin
      r_num_games   <= bus.num_games;
      r_games_run   <= '0;
      r_total_moves <= '0;
      r_best_moves  <= '0;
      r_best_tile   <= '0;
      r_timeouts    <= '0;
    end else if (r_state == ST_NEXT) begin
      r_games_run   <= w_games_inc;
      r_total_moves <= sat_add32(r_total_moves, {16'd0, r_mc});
      if (r_mc > r_best_moves)  r_best_moves <= r_mc;
      if (r_gmax > r_best_tile) r_best_tile  <= r_gmax;
      if (r_timeout)            r_timeouts   <= sat_inc8(r_timeouts);
    end
  end

  // the core only runs in PLAY; holding it in reset elsewhere also freezes its board
  assign bus.core_rst    = (r_state != ST_PLAY);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.games_run   = r_games_run;
  assign bus.total_moves = r_total_moves;
  assign bus.best_moves  = r_best_moves;
  assign bus.best_tile   = r_best_tile;
  assign bus.timeouts    = r_timeouts;

endmodule
`default_nettype wire
